// File: rtl/btn_debounce_if.sv
// Button conditioner signal bundle: raw input in, clean level, edge pulses and press count out.
interface btn_debounce_if #(
    parameter int CNT_W = 8
);
    logic             btn_in;
    logic             btn_out;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] press_cnt;

    // Producer of the raw button level / consumer of the conditioned outputs
    modport master (
        output btn_in,
        input  btn_out, rise_pulse, fall_pulse, press_cnt
    );

    // The debouncer itself
    modport slave (
        input  btn_in,
        output btn_out, rise_pulse, fall_pulse, press_cnt
    );
endinterface

// File: rtl/btn_debounce.sv
// Push-button debouncer: synchronizer chain, 4-state acceptance FSM with a
// stable-run counter, registered level/edge outputs and a wrapping press counter.
module btn_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int STABLE      = 4,
    parameter int CNT_W       = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    btn_debounce_if.slave bus
);
    localparam int SCW = (STABLE < 1) ? 1 : $clog2(STABLE + 1);
    localparam logic [SCW-1:0] LAST = SCW'(STABLE - 1);

    typedef enum logic [1:0] {
        S_LO      = 2'd0,
        S_WAIT_HI = 2'd1,
        S_HI      = 2'd2,
        S_WAIT_LO = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SCW-1:0]         scnt_q, scnt_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   btn_s;

    assign btn_s = sync_q[SYNC_STAGES-1];

    // Synchronizer shift chain; only the last stage is ever looked at
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.btn_in};
    end

    // Next-state and registered-output computation; pulses default low so they last one cycle
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        out_d   = out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_LO: begin
                out_d = 1'b0;
                if (btn_s) begin
                    state_d = S_WAIT_HI;
                    scnt_d  = '0;
                end
            end
            S_WAIT_HI: begin
                out_d = 1'b0;
                if (!btn_s) begin
                    state_d = S_LO;                 // bounce: abandon this run
                end else if (scnt_q == LAST) begin
                    state_d = S_HI;
                    out_d   = 1'b1;
                    rise_d  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);    // wraps naturally
                end else begin
                    scnt_d  = scnt_q + SCW'(1);
                end
            end
            S_HI: begin
                out_d = 1'b1;
                if (!btn_s) begin
                    state_d = S_WAIT_LO;
                    scnt_d  = '0;
                end
            end
            S_WAIT_LO: begin
                out_d = 1'b1;
                if (btn_s) begin
                    state_d = S_HI;                 // bounce: abandon this run
                end else if (scnt_q == LAST) begin
                    state_d = S_LO;
                    out_d   = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    scnt_d  = scnt_q + SCW'(1);
                end
            end
            default: begin
                state_d = S_LO;
                out_d   = 1'b0;
            end
        endcase
    end

    // State, stable counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_LO;
            scnt_q  <= '0;
            out_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
            out_q   <= out_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.btn_out    = out_q;
    assign bus.rise_pulse = rise_q;
    assign bus.fall_pulse = fall_q;
    assign bus.press_cnt  = cnt_q;
endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: directed stimulus pushes expected pulses into a
// scoreboard; a negedge monitor pops and compares each pulse the DUT emits.
module tb_btn_debounce;
    logic clk = 1'b0;
    logic rst_n;
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic       rise;
        logic [7:0] cnt;
        int         edge_no;
    } exp_t;
    exp_t sb[$];

    logic [7:0] cnt_exp;
    logic       prev_pulse;

    btn_debounce_if #(.CNT_W(8)) bus ();

    btn_debounce #(.SYNC_STAGES(2), .STABLE(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Button change at the current negedge: first sampling edge is edge_n+1,
    // accepted level appears 6 edges later.
    task automatic press(input logic v);
        bus.btn_in = v;
        if (v) cnt_exp = cnt_exp + 8'd1;
        sb.push_back('{rise: v, cnt: cnt_exp, edge_no: edge_n + 7});
    endtask

    // Monitor: every pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_pulse = 1'b0;
        end else begin
            if (bus.rise_pulse || bus.fall_pulse) begin
                exp_t e;
                chk("pulse_exclusive", {31'd0, bus.rise_pulse & bus.fall_pulse}, 32'd0);
                chk("pulse_not_back2back", {31'd0, prev_pulse}, 32'd0);
                chk("pulse_expected", {31'd0, sb.size() != 0}, 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("pulse_kind", {31'd0, bus.rise_pulse}, {31'd0, e.rise});
                    chk("pulse_edge", edge_n, e.edge_no);
                    chk("pulse_btn_out", {31'd0, bus.btn_out}, {31'd0, e.rise});
                    chk("pulse_press_cnt", {24'd0, bus.press_cnt}, {24'd0, e.cnt});
                end
            end
            prev_pulse = bus.rise_pulse | bus.fall_pulse;
        end
    end

    initial begin
        cnt_exp    = 8'd0;
        prev_pulse = 1'b0;
        rst_n      = 1'b1;
        bus.btn_in = 1'b1;

        // 1: asynchronous reset between edges
        #3 rst_n = 1'b0;
        #1;
        chk("rst_btn_out", {31'd0, bus.btn_out}, 32'd0);
        chk("rst_rise", {31'd0, bus.rise_pulse}, 32'd0);
        chk("rst_fall", {31'd0, bus.fall_pulse}, 32'd0);
        chk("rst_cnt", {24'd0, bus.press_cnt}, 32'd0);
        repeat (3) @(negedge clk);
        chk("rst_hold_out", {31'd0, bus.btn_out | bus.rise_pulse | bus.fall_pulse}, 32'd0);
        chk("rst_hold_cnt", {24'd0, bus.press_cnt}, 32'd0);

        // release with btn_in=1: normal rise path, one pulse, count 1
        rst_n = 1'b1;
        cnt_exp = cnt_exp + 8'd1;
        sb.push_back('{rise: 1'b1, cnt: cnt_exp, edge_no: edge_n + 7});
        repeat (20) @(negedge clk);

        // 2: release then clean press
        press(1'b0);
        repeat (20) @(negedge clk);
        press(1'b1);
        repeat (20) @(negedge clk);
        chk("clean_level_hi", {31'd0, bus.btn_out}, 32'd1);

        // 3: bounce 1,0,1,0 then held 1; only the final run is accepted
        press(1'b0);
        repeat (20) @(negedge clk);
        bus.btn_in = 1'b1; @(negedge clk);
        bus.btn_in = 1'b0; @(negedge clk);
        bus.btn_in = 1'b1; @(negedge clk);
        bus.btn_in = 1'b0; @(negedge clk);
        press(1'b1);
        repeat (20) @(negedge clk);

        // 4: 3-cycle low glitch from btn_out=1 is rejected
        bus.btn_in = 1'b0;
        repeat (3) @(negedge clk);
        bus.btn_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("glitch_level", {31'd0, bus.btn_out}, 32'd1);
            @(negedge clk);
        end

        // 5: real release, count unchanged
        press(1'b0);
        repeat (20) @(negedge clk);
        chk("release_level", {31'd0, bus.btn_out}, 32'd0);
        chk("release_cnt", {24'd0, bus.press_cnt}, 32'd3);

        // 6: 256 presses wrap the counter back to its starting value
        for (int i = 0; i < 256; i++) begin
            press(1'b1);
            repeat (8) @(negedge clk);
            press(1'b0);
            repeat (8) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("wrap_cnt", {24'd0, bus.press_cnt}, 32'd3);

        // mid-WAIT_HI reset: all outputs drop at once, nothing after release
        bus.btn_in = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out", {31'd0, bus.btn_out | bus.rise_pulse | bus.fall_pulse}, 32'd0);
        chk("midrst_cnt", {24'd0, bus.press_cnt}, 32'd0);
        bus.btn_in = 1'b0;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        cnt_exp = 8'd0;
        repeat (20) @(negedge clk);
        chk("postrst_level", {31'd0, bus.btn_out}, 32'd0);

        // one fresh press after reset counts from zero
        press(1'b1);
        repeat (20) @(negedge clk);

        // every scheduled pulse must have arrived
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
